// File: rtl/case10_parity_monitor_pkg.sv
// Shared types and the golden reference for the case10 parity monitor.
// The golden output is ~(a^b^c); input d is ignored.
package case10_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HALT = 2'd3
    } state_t;

    typedef struct packed {
        logic pass;
        logic split;
    } res_t;

    function automatic logic golden(
        input logic a,
        input logic b,
        input logic c
    );
        return ~(a ^ b ^ c);
    endfunction

endpackage

// File: rtl/case10_parity_monitor_if.sv
// Sample-in and result-out valid/ready channels of the parity monitor.
// The master side feeds samples and consumes results.
interface case10_mon_if;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       in_y1;
    logic       in_y2;
    logic       res_valid;
    logic       res_ready;
    logic       res_pass;
    logic       res_split;

    modport master (
        output in_valid, in_vec, in_y1, in_y2, res_ready,
        input  in_ready, res_valid, res_pass, res_split
    );

    modport slave (
        input  in_valid, in_vec, in_y1, in_y2, res_ready,
        output in_ready, res_valid, res_pass, res_split
    );

endinterface

// File: rtl/case10_parity_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/case10_parity_monitor.sv
// Grades case10 netlist samples against the golden parity function and
// streams one pass/split record per accepted sample.
module case10_parity_monitor
    import case10_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int NUM_SAMPLES = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    case10_mon_if.slave      bus,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state_o
);

    state_t state, state_nx;
    res_t   res_q, res_d;
    logic   res_valid_q;
    logic   accept;
    logic   clr;
    logic   fail;
    logic   exp_v;
    logic   unused_d;

    assign unused_d = bus.in_vec[0];

    assign exp_v = golden(bus.in_vec[3], bus.in_vec[2], bus.in_vec[1]);

    assign res_d.pass  = (bus.in_y1 == exp_v) & (bus.in_y2 == exp_v);
    assign res_d.split = bus.in_y1 ^ bus.in_y2;
    assign fail        = ~res_d.pass;

    // Single result slot: a take frees it for a same-cycle accept.
    assign bus.in_ready = (state == RUN) & (~res_valid_q | bus.res_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign clr          = start & (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, HALT: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (sample_cnt == CNT_W'(NUM_SAMPLES - 1)) begin
                        state_nx = DONE;
                    end else if ((STOP_ON_ERR != 0) && fail) begin
                        state_nx = HALT;
                    end
                end
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (accept) begin
            res_valid_q <= 1'b1;
            res_q       <= res_d;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_pass  = res_q.pass;
    assign bus.res_split = res_q.split;
    assign state_o       = state;

    sat_counter #(.W(CNT_W)) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (accept),
        .q     (sample_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (accept & fail),
        .q     (err_cnt)
    );

endmodule

// File: tb/tb_case10_parity_monitor.sv
// Directed bench for case10_parity_monitor with a result scoreboard.
// Three configurations plus a standalone 2-bit saturating counter.
module tb_case10_parity_monitor;

    typedef struct {
        int   k;
        logic pass;
        logic split;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  iv_v = '0;
    logic [11:0] vec_v = '0;
    logic [2:0]  y1_v = '0;
    logic [2:0]  y2_v = '0;
    logic [2:0]  rr_v = '0;
    logic [2:0]  ir, rv, rp, rs;
    logic [47:0] sc_all, ec_all;
    logic [5:0]  st_all;
    logic [15:0] sc0, ec0, sc1, ec1;
    logic [1:0]  sc2, ec2;
    logic [1:0]  st0, st1, st2;
    logic        sat_clr = 1'b0;
    logic        sat_inc = 1'b0;
    logic [1:0]  sat_q;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    case10_mon_if bus0 ();
    case10_mon_if bus1 ();
    case10_mon_if bus2 ();

    assign bus0.in_valid  = iv_v[0];
    assign bus0.in_vec    = vec_v[3:0];
    assign bus0.in_y1     = y1_v[0];
    assign bus0.in_y2     = y2_v[0];
    assign bus0.res_ready = rr_v[0];
    assign bus1.in_valid  = iv_v[1];
    assign bus1.in_vec    = vec_v[7:4];
    assign bus1.in_y1     = y1_v[1];
    assign bus1.in_y2     = y2_v[1];
    assign bus1.res_ready = rr_v[1];
    assign bus2.in_valid  = iv_v[2];
    assign bus2.in_vec    = vec_v[11:8];
    assign bus2.in_y1     = y1_v[2];
    assign bus2.in_y2     = y2_v[2];
    assign bus2.res_ready = rr_v[2];

    assign ir = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
    assign rv = {bus2.res_valid, bus1.res_valid, bus0.res_valid};
    assign rp = {bus2.res_pass, bus1.res_pass, bus0.res_pass};
    assign rs = {bus2.res_split, bus1.res_split, bus0.res_split};
    assign sc_all = {14'd0, sc2, sc1, sc0};
    assign ec_all = {14'd0, ec2, ec1, ec0};
    assign st_all = {st2, st1, st0};

    case10_parity_monitor dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bus(bus0),
        .sample_cnt(sc0), .err_cnt(ec0), .state_o(st0)
    );

    case10_parity_monitor #(
        .CNT_W(16), .NUM_SAMPLES(4), .STOP_ON_ERR(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bus(bus1),
        .sample_cnt(sc1), .err_cnt(ec1), .state_o(st1)
    );

    case10_parity_monitor #(
        .CNT_W(2), .NUM_SAMPLES(3), .STOP_ON_ERR(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bus(bus2),
        .sample_cnt(sc2), .err_cnt(ec2), .state_o(st2)
    );

    sat_counter #(.W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(sat_clr), .inc(sat_inc), .q(sat_q)
    );

    function automatic logic ref_exp(input logic [3:0] v);
        return ~(v[3] ^ v[2] ^ v[1]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [3:0] vec,
                         input logic a1, input logic a2);
        iv_v[k]        = v;
        vec_v[k*4 +: 4] = vec;
        y1_v[k]        = a1;
        y2_v[k]        = a2;
    endtask

    task automatic chk_st(input int k, input string tag,
                          input logic [15:0] s, input logic [15:0] e,
                          input logic [1:0] st);
        chk({tag, ".sample_cnt"}, 32'(sc_all[k*16 +: 16]), 32'(s));
        chk({tag, ".err_cnt"}, 32'(ec_all[k*16 +: 16]), 32'(e));
        chk({tag, ".state"}, 32'(st_all[k*2 +: 2]), 32'(st));
    endtask

    // Scores the upcoming edge for dut k, then steps to the next negedge.
    task automatic cyc(input int k);
        exp_t e;
        logic x;
        #2;
        if (rv[k] && rr_v[k]) begin
            if (sb.size() == 0) begin
                chk("sb.unexpected_result", 32'(rv[k]), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb.dut", 32'(k), 32'(e.k));
                chk("sb.res_pass", 32'(rp[k]), 32'(e.pass));
                chk("sb.res_split", 32'(rs[k]), 32'(e.split));
            end
        end
        if (iv_v[k] && ir[k]) begin
            x = ref_exp(vec_v[k*4 +: 4]);
            e.k     = k;
            e.pass  = (y1_v[k] == x) && (y2_v[k] == x);
            e.split = y1_v[k] != y2_v[k];
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst.in_ready", 32'(ir[0]), 32'd0);
        chk("rst.res_valid", 32'(rv[0]), 32'd0);
        chk("rst.res_pass", 32'(rp[0]), 32'd0);
        chk("rst.res_split", 32'(rs[0]), 32'd0);
        chk_st(0, "rst", 16'd0, 16'd0, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start in IDLE with a sample already offered.
        rr_v[0] = 1'b1;
        start_v[0] = 1'b1;
        drive(0, 1'b1, 4'b0001, 1'b1, 1'b1);
        #1;
        chk("idle_start.in_ready", 32'(ir[0]), 32'd0);
        cyc(0);
        start_v[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            drive(0, 1'b1, {abc, 1'b1}, ref_exp({abc, 1'b1}),
                  ref_exp({abc, 1'b1}));
            #1;
            chk("run.in_ready", 32'(ir[0]), 32'd1);
            cyc(0);
        end
        drive(0, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(0);
        chk_st(0, "t1", 16'd8, 16'd0, 2'd1);

        drive(0, 1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(0);
        drive(0, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(0);
        chk("t2.err_cnt", 32'(ec0), 32'd1);

        drive(0, 1'b1, 4'b1010, 1'b1, 1'b0);
        cyc(0);
        drive(0, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(0);
        chk("t3.err_cnt", 32'(ec0), 32'd2);

        // Backpressure: a differing failing sample waits on the inputs.
        rr_v[0] = 1'b0;
        drive(0, 1'b1, 4'b1101, 1'b1, 1'b1);
        cyc(0);
        drive(0, 1'b1, 4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.in_ready", 32'(ir[0]), 32'd0);
            chk("bp.res_valid", 32'(rv[0]), 32'd1);
            chk("bp.res_pass", 32'(rp[0]), 32'd1);
            chk("bp.res_split", 32'(rs[0]), 32'd0);
            cyc(0);
        end
        rr_v[0] = 1'b1;
        #1;
        chk("bp_release.in_ready", 32'(ir[0]), 32'd1);
        cyc(0);
        drive(0, 1'b0, 4'b0000, 1'b0, 1'b0);
        start_v[0] = 1'b1;
        cyc(0);
        start_v[0] = 1'b0;
        chk_st(0, "t4", 16'd12, 16'd3, 2'd1);

        // STOP_ON_ERR: second sample fails, record pending across restart.
        rr_v[1] = 1'b1;
        start_v[1] = 1'b1;
        cyc(1);
        start_v[1] = 1'b0;
        drive(1, 1'b1, 4'b0011, 1'b0, 1'b0);
        cyc(1);
        drive(1, 1'b1, 4'b0011, 1'b1, 1'b1);
        cyc(1);
        drive(1, 1'b0, 4'b0000, 1'b0, 1'b0);
        rr_v[1] = 1'b0;
        cyc(1);
        chk_st(1, "halt", 16'd2, 16'd1, 2'd3);
        chk("halt.in_ready", 32'(ir[1]), 32'd0);
        chk("halt.res_valid", 32'(rv[1]), 32'd1);
        start_v[1] = 1'b1;
        cyc(1);
        start_v[1] = 1'b0;
        chk_st(1, "restart", 16'd0, 16'd0, 2'd1);
        chk("restart.res_valid", 32'(rv[1]), 32'd1);
        chk("restart.res_pass", 32'(rp[1]), 32'd0);
        rr_v[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 4'b0011, 1'b0, (i == 3));
            #1;
            chk("restart.in_ready", 32'(ir[1]), 32'd1);
            cyc(1);
        end
        drive(1, 1'b1, 4'b0011, 1'b0, 1'b0);
        #1;
        chk("done.in_ready", 32'(ir[1]), 32'd0);
        chk_st(1, "done", 16'd4, 16'd1, 2'd2);
        cyc(1);
        drive(1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1);

        // Narrow counters: five failing offers, only three accepted.
        rr_v[2] = 1'b1;
        start_v[2] = 1'b1;
        cyc(2);
        start_v[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2, 1'b1, 4'b1111, 1'b1, 1'b1);
            cyc(2);
        end
        drive(2, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk_st(2, "narrow", 16'd3, 16'd3, 2'd2);
        chk("narrow.res_valid", 32'(rv[2]), 32'd0);

        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        sat_inc = 1'b1;
        repeat (3) @(negedge clk);
        chk("sat.q3", 32'(sat_q), 32'd3);
        repeat (2) @(negedge clk);
        sat_inc = 1'b0;
        chk("sat.q5", 32'(sat_q), 32'd3);
        chk("sb.empty", 32'(sb.size()), 32'd0);

        // Async reset with a pending record on dut0.
        rr_v[0] = 1'b0;
        drive(0, 1'b1, 4'b1001, 1'b0, 1'b0);
        cyc(0);
        drive(0, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("pre_rst.res_valid", 32'(rv[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.in_ready", 32'(ir[0]), 32'd0);
        chk("arst.res_valid", 32'(rv[0]), 32'd0);
        chk("arst.res_pass", 32'(rp[0]), 32'd0);
        chk("arst.res_split", 32'(rs[0]), 32'd0);
        chk_st(0, "arst", 16'd0, 16'd0, 2'd0);
        sb.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
